// File: rtl/bk_pkg.sv
// Shared types and sizing helpers for the nibble-serial Brent-Kung adder.
package bk_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibble steps needed for a WIDTH-bit operand.
  function automatic int nibble_count(input int width);
    return width / NIBBLE;
  endfunction

  // Width of the nibble index register, never less than one bit.
  function automatic int index_width(input int width);
    int n;
    n = width / NIBBLE;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brent_kung_cin.sv
// 4-bit Brent-Kung prefix adder with carry-in, used as the nibble datapath.
module brent_kung_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g0c;
  logic       g10;
  logic       g32;
  logic       p32;
  logic       g20;
  logic       g30;

  // Bit generate/propagate, with the carry-in folded into bit 0's generate.
  always_comb begin
    g   = a & b;
    p   = a ^ b;
    g0c = g[0] | (p[0] & cin);
  end

  // Up-sweep of the prefix tree, then the single down-sweep node for bit 2.
  always_comb begin
    g10 = g[1] | (p[1] & g0c);
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g30 = g32 | (p32 & g10);
    g20 = g[2] | (p[2] & g10);
  end

  // Sum bits from propagates and the prefix carries.
  always_comb begin
    sum  = p ^ {g20, g10, g0c, cin};
    cout = g30;
  end

endmodule

// File: rtl/bk_serial_add_seq.sv
// Nibble-serial WIDTH-bit adder built around one brent_kung_cin instance.
// Optional subtraction (A - B) is compiled in when BK_SEQ_SUB_EN is defined.
module bk_serial_add_seq
  import bk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int N    = nibble_count(WIDTH);
  localparam int IDXW = index_width(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              cout_q;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW+1:0]   nib_base;
  logic              accept;
  logic              last;
  logic [WIDTH-1:0]  b_load;
  logic              carry_load;
  logic [NIBBLE-1:0] nib_a;
  logic [NIBBLE-1:0] nib_b;
  logic [NIBBLE-1:0] nib_sum;
  logic              nib_cout;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last      = (idx_q == LAST_IDX);
  assign nib_base  = {idx_q, 2'b00};
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

`ifdef BK_SEQ_SUB_EN
  // Subtraction stores ~B and forces the carry-in so the adder computes A + ~B + 1.
  always_comb begin
    b_load     = in_sub ? ~in_b : in_b;
    carry_load = in_sub ? 1'b1 : in_cin;
  end
`else
  logic unused_sub;
  assign unused_sub = in_sub;

  // Plain addition only; the subtract request has no effect in this build.
  always_comb begin
    b_load     = in_b;
    carry_load = in_cin;
  end
`endif

  // Select the operand nibbles for the current step.
  always_comb begin
    nib_a = a_q[nib_base +: NIBBLE];
    nib_b = b_q[nib_base +: NIBBLE];
  end

  brent_kung_cin u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept, step through N nibbles, then hold the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand latch, per-nibble sum write-back and carry chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= b_load;
            carry_q <= carry_load;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[nib_base +: NIBBLE] <= nib_sum;
          carry_q                   <= nib_cout;
          if (last) begin
            cout_q <= nib_cout;
            idx_q  <= '0;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bk_serial_add_seq.sv
// Self-checking bench for bk_serial_add_seq at WIDTH=16.
module tb_bk_serial_add_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

  bk_serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: {cout, result} from plain integer math.
  function automatic logic [W:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`ifdef BK_SEQ_SUB_EN
    if (sub) r = {(a >= b), W'(a - b)};
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for in_ready, hand over one operation and collect its result with out_ready=1.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic sub, output logic [W-1:0] sum, output logic cout,
                               output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    checkOutput("out_valid_wait", 32'(out_valid), 32'd1);
    sum  = out_sum;
    cout = out_cout;
  endtask

  initial begin
    logic [W-1:0] s;
    logic         c;
    int           lat;
    logic [W:0]   ref_val;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0};
`ifdef BK_SEQ_SUB_EN
    vecs[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
`else
    vecs[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0};
`endif
    vecs[5] = '{16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready_after", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_out_cout", 32'(out_cout), 32'd0);

    // Directed table, including latency and return of in_ready.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, c, lat);
      checkOutput($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
      checkOutput($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].exp_cout));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready_back", i), 32'(in_ready), 32'd1);
    end

    // Result held under back-pressure while new operands are offered.
    @(negedge clk);
    in_a = 16'h00FF; in_b = 16'h0000; in_cin = 1'b1; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    checkOutput("hold_latency", 32'(lat), 32'd5);
    in_a = 16'h1111; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("hold%0d_sum", k), 32'(out_sum), 32'h0100);
      checkOutput($sformatf("hold%0d_cout", k), 32'(out_cout), 32'd0);
      checkOutput($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_release_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    checkOutput("post_hold_latency", 32'(lat), 32'd5);
    checkOutput("post_hold_sum", 32'(out_sum), 32'h2222);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_partial_sum", 32'(out_sum), 32'h0003);
    checkOutput("abort_in_ready_rst", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_out_sum", 32'(out_sum), 32'd0);
    checkOutput("abort_out_cout", 32'(out_cout), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0, s, c, lat);
    checkOutput("after_abort_sum", 32'(s), 32'h1010);
    checkOutput("after_abort_cout", 32'(c), 32'd0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ref_val = refModel(ra, rb, rc, rs);
      applyStimulus(ra, rb, rc, rs, s, c, lat);
      checkOutput($sformatf("rand%0d_sum a=%h b=%h cin=%0d sub=%0d", i, ra, rb, rc, rs),
                  32'(s), 32'(ref_val[W-1:0]));
      checkOutput($sformatf("rand%0d_cout", i), 32'(c), 32'(ref_val[W]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
